// File: rtl/nvram_upload_reader_if.sv
// Upload-side bundle between data_io, the NVRAM upload reader and the CMOS RAM read port.
// The reader uses the slave modport; the host/RAM environment uses the master modport.
interface nvram_upload_reader_if #(
  parameter int AW = 10
);
  logic          ioctl_upl;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic          up_rd;
  logic [7:0]    up_data;
  logic          up_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic          ram_busy;
  logic [7:0]    ram_q;
  logic          done;
  logic          sync_err;

  modport slave (
    input  ioctl_upl, ioctl_index, ioctl_addr, up_rd, ram_busy, ram_q,
    output up_data, up_ready, ram_addr, ram_rd, done, sync_err
  );

  modport master (
    output ioctl_upl, ioctl_index, ioctl_addr, up_rd, ram_busy, ram_q,
    input  up_data, up_ready, ram_addr, ram_rd, done, sync_err
  );
endinterface

// File: rtl/nvram_upload_reader.sv
// Streams the CMOS high-score RAM into the data_io upload byte, one byte per ready/consume
// handshake, reading the RAM only in cycles the CPU leaves the shared port free.
module nvram_upload_reader #(
  parameter int          AW    = 10,
  parameter logic [7:0]  INDEX = 8'hFF
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  nvram_upload_reader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_READY = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          upl_q;
  logic          armed_q;
  logic          start_s;
  logic          ram_rd_s;
  logic          unused_addr_s;

  // armed_q blocks a start until ioctl_upl has been seen low since reset, so a level
  // that is still high when reset releases is not mistaken for a fresh rising edge.
  assign start_s = bus.ioctl_upl & ~upl_q & armed_q & (bus.ioctl_index == INDEX);
  assign unused_addr_s = ^bus.ioctl_addr[24:AW];

  // State, pointer, output byte and flag registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      upl_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      upl_q   <= bus.ioctl_upl;
      armed_q <= armed_q | ~bus.ioctl_upl;
    end
  end

  // Next-state and read-strobe logic; an upload drop outranks every other transition.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = err_q;
    ram_rd_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          ptr_d   = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        ram_rd_s = ~bus.ram_busy;
        if (bus.ram_busy) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        data_d  = bus.ram_q;
        state_d = S_READY;
      end
      S_READY: begin
        if (bus.up_rd) begin
          if (bus.ioctl_addr[AW-1:0] != ptr_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (&ptr_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + {{(AW-1){1'b0}}, 1'b1};
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_READY;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && !bus.ioctl_upl) begin
      state_d = S_IDLE;
      ptr_d   = ptr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;
    end else begin
      state_d = state_d;
    end
  end

  assign bus.up_data  = data_q;
  assign bus.up_ready = (state_q == S_READY);
  assign bus.ram_addr = ptr_q;
  assign bus.ram_rd   = ram_rd_s;
  assign bus.done     = done_q;
  assign bus.sync_err = err_q;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed-plus-random bench for nvram_upload_reader: a RAM image and expected byte order,
// latency and sync flag are kept in the bench and compared with immediate assertions.
module tb_nvram_upload_reader;

  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] mem [0:N-1];
  int         checks   = 0;
  int         failures = 0;
  bit         model_err;

  nvram_upload_reader_if #(.AW(AW)) bus ();

  nvram_upload_reader #(.AW(AW), .INDEX(8'hFF)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // CMOS RAM: data valid the cycle after a granted read; otherwise junk from CPU traffic.
  always @(posedge clk_sys) begin
    if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];
    else            bus.ram_q <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(bus.up_data), 32'h0);
    chk({tag, "_ready"}, 32'(bus.up_ready), 32'h0);
    chk({tag, "_rd"}, 32'(bus.ram_rd), 32'h0);
    chk({tag, "_addr"}, 32'(bus.ram_addr), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_err"}, 32'(bus.sync_err), 32'h0);
  endtask

  // Entry: just after the edge with ioctl_upl raised; exit: first ISSUE cycle.
  task automatic begin_upload(input logic [7:0] idx);
    bus.ioctl_index = idx;
    bus.ioctl_upl   = 1'b1;
    #1;
    chk("idle_rd", 32'(bus.ram_rd), 32'h0);
    chk("idle_ready", 32'(bus.up_ready), 32'h0);
    tick();
    model_err = 1'b0;
  endtask

  // Entry: first ISSUE cycle of byte i; exit: first READY cycle, data checked.
  task automatic to_ready(input int i, input int busy_cycles, input bit spurious);
    chk("issue_addr", 32'(bus.ram_addr), 32'(i));
    for (int j = 0; j < busy_cycles; j++) begin
      bus.ram_busy = 1'b1;
      #1;
      chk("busy_rd", 32'(bus.ram_rd), 32'h0);
      chk("busy_ready", 32'(bus.up_ready), 32'h0);
      tick();
    end
    bus.ram_busy = 1'b0;
    #1;
    chk("grant_rd", 32'(bus.ram_rd), 32'h1);
    tick();
    chk("wait_ready", 32'(bus.up_ready), 32'h0);
    if (spurious) begin
      bus.up_rd      = 1'b1;
      bus.ioctl_addr = 25'($urandom);
    end
    tick();
    bus.up_rd = 1'b0;
    chk("byte_ready", 32'(bus.up_ready), 32'h1);
    chk("byte_data", 32'(bus.up_data), 32'(mem[i]));
  endtask

  // Entry: a READY cycle of byte i; consumes it, exit: next ISSUE (or DONE) cycle.
  task automatic consume(input int i, input int extra, input logic [24:0] addr_val);
    for (int j = 0; j < extra; j++) begin
      tick();
      chk("hold_ready", 32'(bus.up_ready), 32'h1);
      chk("hold_data", 32'(bus.up_data), 32'(mem[i]));
    end
    bus.ioctl_addr = addr_val;
    bus.up_rd      = 1'b1;
    if (addr_val[AW-1:0] != AW'(i)) model_err = 1'b1;
    tick();
    bus.up_rd = 1'b0;
    chk("sync_err", 32'(bus.sync_err), 32'(model_err));
  endtask

  task automatic end_upload();
    bus.ioctl_upl = 1'b0;
    tick();
    chk("end_ready", 32'(bus.up_ready), 32'h0);
    chk("end_rd", 32'(bus.ram_rd), 32'h0);
  endtask

  initial begin
    bus.ioctl_upl   = 1'b0;
    bus.ioctl_index = 8'h00;
    bus.ioctl_addr  = 25'h0;
    bus.up_rd       = 1'b0;
    bus.ram_busy    = 1'b0;
    bus.ram_q       = 8'h00;
    for (int a = 0; a < N; a++) mem[a] = 8'(a) ^ 8'h5A;

    // Reset state
    #12;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    tick();
    chk_reset_outputs("post_reset");

    // Full dump with CPU contention on byte 3 and occasional spurious strobes in WAIT
    begin_upload(8'hFF);
    for (int i = 0; i < N; i++) begin
      to_ready(i, (i == 3) ? 5 : 0, ($urandom_range(0, 7) == 0));
      consume(i, $urandom_range(0, 2), 25'(i));
      if (i == N - 1) begin
        chk("done_pulse", 32'(bus.done), 32'h1);
        chk("done_ready", 32'(bus.up_ready), 32'h0);
      end else begin
        chk("no_done", 32'(bus.done), 32'h0);
      end
    end
    tick();
    chk("done_single", 32'(bus.done), 32'h0);
    chk("done_rd", 32'(bus.ram_rd), 32'h0);
    chk("dump_err", 32'(bus.sync_err), 32'h0);
    end_upload();

    // Wrong index: no transfer, even if the index changes while the level stays high
    begin_upload(8'h00);
    for (int j = 0; j < 6; j++) begin
      if (j == 3) bus.ioctl_index = 8'hFF;
      #1;
      chk("wrong_idx_rd", 32'(bus.ram_rd), 32'h0);
      chk("wrong_idx_ready", 32'(bus.up_ready), 32'h0);
      tick();
    end
    end_upload();

    // Random image, random contention, abort in READY at byte 100
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
    begin_upload(8'hFF);
    for (int i = 0; i <= 100; i++) begin
      to_ready(i, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      if (i < 100) consume(i, $urandom_range(0, 2), 25'(i));
    end
    bus.ioctl_upl = 1'b0;
    tick();
    chk("abort_ready", 32'(bus.up_ready), 32'h0);
    chk("abort_data", 32'(bus.up_data), 32'(mem[100]));
    chk("abort_ptr", 32'(bus.ram_addr), 32'd100);
    chk("abort_err", 32'(bus.sync_err), 32'h0);

    // Restart from 0 with the reference image; host address off by one at ptr 6
    for (int a = 0; a < N; a++) mem[a] = 8'(a) ^ 8'h5A;
    begin_upload(8'hFF);
    chk("restart_addr", 32'(bus.ram_addr), 32'h0);
    for (int i = 0; i < 10; i++) begin
      to_ready(i, $urandom_range(0, 2), 1'b0);
      if (i == 0) chk("restart_first", 32'(bus.up_data), 32'h5A);
      consume(i, 0, (i == 6) ? 25'd7 : 25'(i));
    end
    chk("err_sticky", 32'(bus.sync_err), 32'h1);
    end_upload();
    chk("err_hold_idle", 32'(bus.sync_err), 32'h1);
    begin_upload(8'hFF);
    chk("err_cleared", 32'(bus.sync_err), 32'h0);

    // Asynchronous reset mid-transfer, with ioctl_upl left high across release
    for (int i = 0; i < 3; i++) begin
      to_ready(i, 0, 1'b0);
      consume(i, 0, 25'(i));
    end
    bus.ram_busy = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("hold_off_rd", 32'(bus.ram_rd), 32'h0);
      chk("hold_off_ready", 32'(bus.up_ready), 32'h0);
      tick();
    end
    bus.ioctl_upl = 1'b0;
    tick();
    begin_upload(8'hFF);
    to_ready(0, 0, 1'b0);
    chk("post_reset_first", 32'(bus.up_data), 32'h5A);
    end_upload();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
